// File: rtl/athos_trng_pp_pkg.sv
// Shared types and defaults for the ATHOS TRNG post-processing stage.
// Optional feature macro: ATHOS_TRNG_HEALTH_TEST_EN (repetition-count health test).
package athos_trng_pp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    FAIL    = 2'd3
  } pp_state_t;

  localparam int N_BITS_KEY_DEFAULT = 128;
  localparam int REP_CUTOFF_DEFAULT = 32;

endpackage

// File: rtl/athos_trng_vn_debias.sv
// Von Neumann debiaser: pairs accepted raw bits, emits the first bit of an
// unequal pair on the second bit's cycle, and emits nothing for equal pairs.
// flush returns the pair phase to "first bit" whenever collection stops.
module athos_trng_vn_debias (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  logic in_bit,
  output logic emit_valid,
  output logic emit_bit
);

  logic phase;
  logic first_bit;

  // Pair phase and stored first bit; flush wins over a bit arriving the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      first_bit <= 1'b0;
    end else if (flush) begin
      phase <= 1'b0;
    end else if (in_valid) begin
      phase <= ~phase;
      if (!phase) first_bit <= in_bit;
    end
  end

  assign emit_valid = in_valid & phase & (first_bit != in_bit);
  assign emit_bit   = first_bit;

endmodule

// File: rtl/athos_trng_postproc.sv
// ATHOS TRNG post-processing top: von Neumann debiasing, key assembly and a
// valid/ready key interface. The repetition-count health test and FAIL state
// exist only when ATHOS_TRNG_HEALTH_TEST_EN is defined; otherwise
// health_fail_o is tied low and REP_CUTOFF is accepted but unused.
module athos_trng_postproc
  import athos_trng_pp_pkg::*;
#(
  parameter int N_BITS_KEY = N_BITS_KEY_DEFAULT,
  parameter int REP_CUTOFF = REP_CUTOFF_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic                  raw_bit_i,
  input  logic                  raw_valid_i,
  output logic [N_BITS_KEY-1:0] key_o,
  output logic                  key_valid_o,
  input  logic                  key_ready_i,
  output logic                  health_fail_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(N_BITS_KEY + 1);

  if (N_BITS_KEY < 2 || REP_CUTOFF < 2) begin : g_bad_params
    $error("athos_trng_postproc: N_BITS_KEY and REP_CUTOFF must both be >= 2");
  end

  pp_state_t              state;
  pp_state_t              next_state;
  logic [CNT_W-1:0]       bit_count;
  logic [N_BITS_KEY-1:0]  key_reg;
  logic                   accept;
  logic                   handshake;
  logic                   flush;
  logic                   emit_valid;
  logic                   emit_bit;
  logic                   key_done;
  logic                   fail_hit;

  assign accept    = (state == COLLECT) && raw_valid_i;
  assign handshake = key_valid_o && key_ready_i;
  assign flush     = (state == COLLECT) && (next_state != COLLECT);
  assign key_done  = emit_valid && (bit_count == CNT_W'(N_BITS_KEY - 1));

  athos_trng_vn_debias u_debias (
    .clk        (clk_i),
    .rst        (rst_i),
    .flush      (flush),
    .in_valid   (accept),
    .in_bit     (raw_bit_i),
    .emit_valid (emit_valid),
    .emit_bit   (emit_bit)
  );

`ifdef ATHOS_TRNG_HEALTH_TEST_EN
  localparam int REP_W = $clog2(REP_CUTOFF + 1);

  logic [REP_W-1:0] rep_count;
  logic [REP_W-1:0] rep_next;
  logic             last_bit;

  // Run length the current accepted bit would produce; a zero count means
  // no bit has been accepted since leaving IDLE.
  always_comb begin
    rep_next = REP_W'(1);
    if (rep_count != '0 && raw_bit_i == last_bit) rep_next = rep_count + REP_W'(1);
  end

  assign fail_hit = accept && (rep_next == REP_W'(REP_CUTOFF));

  // Run counter over accepted raw bits, restarted whenever the FSM sits in IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rep_count <= '0;
      last_bit  <= 1'b0;
    end else if (clear_i || state == IDLE) begin
      rep_count <= '0;
    end else if (accept) begin
      rep_count <= rep_next;
      last_bit  <= raw_bit_i;
    end
  end
`else
  assign fail_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // Next state: clear beats everything, then enable drop, then health failure, then key completion.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (enable_i) next_state = COLLECT;
      end
      COLLECT: begin
        if (!enable_i)     next_state = IDLE;
        else if (fail_hit) next_state = FAIL;
        else if (key_done) next_state = FULL;
      end
      FULL: begin
        if (handshake) next_state = enable_i ? COLLECT : IDLE;
      end
      FAIL: begin
        next_state = FAIL;
      end
      default: next_state = IDLE;
    endcase
    if (clear_i) next_state = IDLE;
  end

  // Key assembly: emitted bit k lands in key bit k; a discarded partial key only resets the counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_count <= '0;
      key_reg   <= '0;
    end else begin
      if (next_state == IDLE || next_state == FAIL || handshake) begin
        bit_count <= '0;
      end else if (emit_valid) begin
        bit_count <= bit_count + CNT_W'(1);
      end
      if (emit_valid && (next_state == COLLECT || next_state == FULL)) begin
        for (int i = 0; i < N_BITS_KEY; i++) begin
          if (bit_count == CNT_W'(i)) key_reg[i] <= emit_bit;
        end
      end
    end
  end

  // Registered status outputs mirror the state being entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      key_valid_o <= (next_state == FULL);
      busy_o      <= (next_state == COLLECT);
    end
  end

`ifdef ATHOS_TRNG_HEALTH_TEST_EN
  // Sticky failure flag, held while the FSM stays in FAIL.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) health_fail_o <= 1'b0;
    else       health_fail_o <= (next_state == FAIL);
  end
`else
  assign health_fail_o = 1'b0;
`endif

  assign key_o = key_reg;

endmodule

// File: tb/tb_athos_trng_postproc.sv
// Self-checking bench for athos_trng_postproc (N_BITS_KEY=8, REP_CUTOFF=4).
// Health-test expectations follow ATHOS_TRNG_HEALTH_TEST_EN.
module tb_athos_trng_postproc;

  localparam int N   = 8;
  localparam int REP = 4;
`ifdef ATHOS_TRNG_HEALTH_TEST_EN
  localparam bit HT = 1'b1;
`else
  localparam bit HT = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_COL  = 1;
  localparam int M_FULL = 2;
  localparam int M_FAIL = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         clear;
  logic         raw_bit;
  logic         raw_valid;
  logic         key_ready;
  logic [N-1:0] key;
  logic         key_valid;
  logic         health_fail;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Reference model: abstract state, pending first bit, emitted bit count, run length.
  int           m_st;
  bit           m_pend;
  bit           m_first;
  bit           m_last;
  int           m_cnt;
  int           m_run;
  logic [N-1:0] m_key;

  typedef struct {
    bit           en;
    bit           clr;
    bit           b;
    bit           v;
    bit           rdy;
    logic [N-1:0] key;
    bit           valid;
    bit           busy;
  } vec_t;

  vec_t vecs[18];
  bit   pat[16] = '{1,0,0,1, 1,0,0,1, 1,0,0,1, 1,0,0,1};
  logic [N-1:0] pat_keys[16] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h05, 8'h05, 8'h05,
                                 8'h05, 8'h15, 8'h15, 8'h15, 8'h15, 8'h55, 8'h55, 8'h55};

  athos_trng_postproc #(.N_BITS_KEY(N), .REP_CUTOFF(REP)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .clear_i       (clear),
    .raw_bit_i     (raw_bit),
    .raw_valid_i   (raw_valid),
    .key_o         (key),
    .key_valid_o   (key_valid),
    .key_ready_i   (key_ready),
    .health_fail_o (health_fail),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    m_st    = M_IDLE;
    m_pend  = 1'b0;
    m_first = 1'b0;
    m_last  = 1'b0;
    m_cnt   = 0;
    m_run   = 0;
    m_key   = '0;
  endfunction

  function automatic void modelStep(bit en, bit clr, bit b, bit v, bit rdy);
    if (clr) begin
      m_st = M_IDLE; m_cnt = 0; m_pend = 1'b0; m_run = 0;
      return;
    end
    case (m_st)
      M_IDLE: begin
        m_run = 0;
        if (en) m_st = M_COL;
      end
      M_COL: begin
        if (!en) begin
          m_st = M_IDLE; m_cnt = 0; m_pend = 1'b0; m_run = 0;
        end else if (v) begin
          m_run  = (m_run == 0 || b != m_last) ? 1 : m_run + 1;
          m_last = b;
          if (HT && m_run >= REP) begin
            m_st = M_FAIL; m_cnt = 0; m_pend = 1'b0;
          end else if (!m_pend) begin
            m_pend = 1'b1; m_first = b;
          end else begin
            m_pend = 1'b0;
            if (m_first != b) begin
              m_key[m_cnt] = m_first;
              m_cnt++;
              if (m_cnt == N) m_st = M_FULL;
            end
          end
        end
      end
      M_FULL: begin
        if (rdy) begin
          m_cnt = 0;
          m_st  = en ? M_COL : M_IDLE;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkKey(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkBit("model_key_valid", key_valid, m_st == M_FULL);
    checkKey("model_key", key, m_key);
    checkBit("model_health_fail", health_fail, m_st == M_FAIL);
    checkBit("model_busy", busy, m_st == M_COL);
  endtask

  task automatic applyStimulus(input bit en, input bit clr, input bit b, input bit v, input bit rdy);
    enable    = en;
    clear     = clr;
    raw_bit   = b;
    raw_valid = v;
    key_ready = rdy;
    @(posedge clk);
    modelStep(en, clr, b, v, rdy);
    #1;
    checkOutput();
  endtask

  task automatic sendPattern();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, pat[i], 1'b1, 1'b0);
  endtask

  task automatic doClear();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit seq2[10] = '{1,1,0,0,1,1,0,0,0,1};
    bit rb;
    bit clr_r;

    rst = 1'b1; enable = 1'b0; clear = 1'b0; raw_bit = 1'b0; raw_valid = 1'b0; key_ready = 1'b0;
    modelReset();
    #12;
    checkBit("reset_key_valid", key_valid, 1'b0);
    checkKey("reset_key", key, '0);
    checkBit("reset_health_fail", health_fail, 1'b0);
    checkBit("reset_busy", busy, 1'b0);
    rst = 1'b0;

    // Table: enable, 1,0,0,1 x4, then handshake with enable held.
    vecs[0] = '{en:1, clr:0, b:0, v:0, rdy:0, key:8'h00, valid:0, busy:1};
    for (int i = 0; i < 16; i++)
      vecs[i+1] = '{en:1, clr:0, b:pat[i], v:1, rdy:0, key:pat_keys[i], valid:(i == 15), busy:(i != 15)};
    vecs[17] = '{en:1, clr:0, b:0, v:0, rdy:1, key:8'h55, valid:0, busy:1};
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].en, vecs[i].clr, vecs[i].b, vecs[i].v, vecs[i].rdy);
      checkBit("tbl_valid", key_valid, vecs[i].valid);
      checkKey("tbl_key", key, vecs[i].key);
      checkBit("tbl_busy", busy, vecs[i].busy);
      checkBit("tbl_fail", health_fail, 1'b0);
    end

    // Mostly equal pairs: only the last pair emits, then seven more ones fill the key.
    doClear();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, seq2[i], 1'b1, 1'b0);
    checkBit("eq_pairs_valid", key_valid, 1'b0);
    checkBit("eq_pairs_busy", busy, 1'b1);
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, (i % 2 == 0), 1'b1, 1'b0);
    checkBit("eq_pairs_full", key_valid, 1'b1);
    checkKey("eq_pairs_key", key, 8'hFE);

    // Repetition failure; clear pulse has priority over enable.
    doClear();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkBit("rep3_no_fail", health_fail, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkBit("rep4_fail", health_fail, HT);
    checkBit("rep4_no_key", key_valid, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkBit("rep_sticky", health_fail, HT);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkBit("clear_fail", health_fail, 1'b0);
    checkBit("clear_idle", busy, 1'b0);

    // Backpressure: key held, raw bits dropped, next key from fresh bits.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPattern();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)), 1'b1, 1'b0);
      checkKey("bp_key_stable", key, 8'h55);
      checkBit("bp_valid_held", key_valid, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkBit("bp_handshake_valid", key_valid, 1'b0);
    checkBit("bp_handshake_busy", busy, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, (i % 2 == 1), 1'b1, 1'b0);
    checkBit("bp_next_valid", key_valid, 1'b1);
    checkKey("bp_next_key", key, 8'h00);

    // Clear during a handshake wins: straight to IDLE.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkBit("clr_hs_valid", key_valid, 1'b0);
    checkBit("clr_hs_busy", busy, 1'b0);

    // Enable drop after 6 bits discards the partial key.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, pat[i], 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkBit("endrop_busy", busy, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, pat[i], 1'b1, 1'b0);
    checkBit("endrop_not_yet", key_valid, 1'b0);
    applyStimulus(1'b1, 1'b0, pat[15], 1'b1, 1'b0);
    checkBit("endrop_valid", key_valid, 1'b1);
    checkKey("endrop_key", key, 8'h55);

    // Asynchronous reset while FULL.
    #2 rst = 1'b1;
    #1;
    checkBit("arst_key_valid", key_valid, 1'b0);
    checkKey("arst_key", key, '0);
    checkBit("arst_busy", busy, 1'b0);
    checkBit("arst_fail", health_fail, 1'b0);
    modelReset();
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkBit("arst_idle", busy, 1'b0);

    // Randomized traffic against the model.
    rb = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(2) != 0) rb = 1'($urandom_range(1));
      clr_r = (m_st == M_FAIL) ? ($urandom_range(4) == 0) : ($urandom_range(80) == 0);
      applyStimulus(($urandom_range(19) != 0), clr_r, rb, ($urandom_range(3) != 0),
                    ($urandom_range(2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
